// File: rtl/osu_clkdiv_pkg.sv
// rtl/osu_clkdiv_pkg.sv - shared types and ratio helpers for the clock divider/gate
package osu_clkdiv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic MODE_TOGGLE = 1'b0;
   localparam logic MODE_PULSE  = 1'b1;

   // Ratios of 0 and 1 cannot produce a period with both a high and a low phase.
   function automatic int unsigned clamp_ratio(input int unsigned d);
      return (d < 2) ? 2 : d;
   endfunction

   function automatic int unsigned half_period(input int unsigned r);
      return (r + 1) / 2;
   endfunction

endpackage

// File: rtl/osu_clkdiv_chan.sv
// rtl/osu_clkdiv_chan.sv - one divider channel: FSM, period counter, active/pending ratio, output flops
module osu_clkdiv_chan
   import osu_clkdiv_pkg::*;
#(
   parameter int DIVW    = 8,
   parameter int DIV_RST = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            load,
   input  logic [DIVW-1:0] div,
   input  logic            mode,
   output logic            y,
   output logic            tick,
   output logic            busy
);

   state_t            state, state_n;
   logic [DIVW-1:0]   cnt, cnt_n;
   logic [DIVW-1:0]   act_r, act_r_n, pend_r, pend_r_n, ld_r;
   logic              act_m, act_m_n, pend_m, pend_m_n, pend_v, pend_v_n;
   logic              wrap, busy_n, y_n, tick_n;

   assign ld_r = DIVW'(clamp_ratio(32'(div)));

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      act_r_n  = act_r;
      act_m_n  = act_m;
      pend_r_n = pend_r;
      pend_m_n = pend_m;
      pend_v_n = pend_v;
      wrap     = (state != IDLE) && (cnt == act_r - DIVW'(1));

      case (state)
         IDLE: begin
            if (pend_v) begin
               act_r_n  = pend_r;
               act_m_n  = pend_m;
               pend_v_n = 1'b0;
            end
            if (load) begin
               act_r_n = ld_r;
               act_m_n = mode;
            end
            if (en) begin
               state_n = RUN;
               cnt_n   = '0;
            end
         end
         RUN, DRAIN: begin
            cnt_n = wrap ? '0 : cnt + DIVW'(1);
            if (wrap && pend_v) begin
               act_r_n  = pend_r;
               act_m_n  = pend_m;
               pend_v_n = 1'b0;
            end
            // A load on the wrap edge lands in pending after the swap above, so it waits a period.
            if (load) begin
               pend_r_n = ld_r;
               pend_m_n = mode;
               pend_v_n = 1'b1;
            end
            if (en)
               state_n = RUN;
            else if (state == DRAIN && wrap)
               state_n = IDLE;
            else
               state_n = DRAIN;
         end
         default: state_n = IDLE;
      endcase

      busy_n = (state_n != IDLE);
      if (act_m_n == MODE_PULSE)
         y_n = busy_n && (cnt_n == '0);
      else
         y_n = busy_n && (32'(cnt_n) < half_period(32'(act_r_n)));
      tick_n = busy_n && (cnt_n == act_r_n - DIVW'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         act_r  <= DIVW'(clamp_ratio(DIV_RST));
         act_m  <= MODE_TOGGLE;
         pend_r <= '0;
         pend_m <= MODE_TOGGLE;
         pend_v <= 1'b0;
         y      <= 1'b0;
         tick   <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         act_r  <= act_r_n;
         act_m  <= act_m_n;
         pend_r <= pend_r_n;
         pend_m <= pend_m_n;
         pend_v <= pend_v_n;
         y      <= y_n;
         tick   <= tick_n;
         busy   <= busy_n;
      end
   end

endmodule

// File: rtl/osu_clkdiv_gate.sv
// rtl/osu_clkdiv_gate.sv - multi-channel glitch-free clock divider / strobe generator
module osu_clkdiv_gate
   import osu_clkdiv_pkg::*;
#(
   parameter int NCH     = 4,
   parameter int DIVW    = 8,
   parameter int DIV_RST = 2
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [NCH-1:0]      EN,
   input  logic [NCH-1:0]      LOAD,
   input  logic [NCH*DIVW-1:0] DIV,
   input  logic [NCH-1:0]      MODE,
   output logic [NCH-1:0]      Y,
   output logic [NCH-1:0]      TICK,
   output logic [NCH-1:0]      BUSY
);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      osu_clkdiv_chan #(
         .DIVW    (DIVW),
         .DIV_RST (DIV_RST)
      ) u_chan (
         .clk  (CLK),
         .rst  (RST),
         .en   (EN[i]),
         .load (LOAD[i]),
         .div  (DIV[i*DIVW +: DIVW]),
         .mode (MODE[i]),
         .y    (Y[i]),
         .tick (TICK[i]),
         .busy (BUSY[i])
      );
   end

endmodule
